// File: rtl/turn_timer.sv
// Per-turn countdown timer for a two-player game FSM.
// Counts whole seconds down from TURN_SECONDS and emits a single-cycle timeout strobe.
module turn_timer #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int TURN_SECONDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] current_state,
    input  logic       player_mov,
    output logic       timer_out,
    output logic [4:0] seconds_left,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_active
);

    localparam int             PW       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]  PRE_MAX  = PW'(CLK_FREQ - 1);
    localparam logic [4:0]     TURN_VAL = 5'(TURN_SECONDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t         state_r;
    logic [2:0]     prev_state_r;
    logic [PW-1:0]  prescaler_r;

    logic player_turn_s;
    logic turn_change_s;
    logic reload_s;
    logic tick_s;

    // Binary 0..31 to two BCD digits without a divider.
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [7:0] r;
        if (v >= 5'd30) begin
            r = {4'd3, 4'(v - 5'd30)};
        end else if (v >= 5'd20) begin
            r = {4'd2, 4'(v - 5'd20)};
        end else if (v >= 5'd10) begin
            r = {4'd1, 4'(v - 5'd10)};
        end else begin
            r = {4'd0, v[3:0]};
        end
        return r;
    endfunction

    // Turn bookkeeping decoded from the game FSM state and the move strobe.
    always_comb begin
        player_turn_s = (current_state == 3'd1) || (current_state == 3'd2);
        turn_change_s = (current_state != prev_state_r);
        reload_s      = (player_mov || turn_change_s) && player_turn_s;
        tick_s        = (prescaler_r == PRE_MAX);
    end

    // Countdown FSM; every output is registered and the BCD digits track seconds_left.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                <= IDLE;
            prev_state_r           <= 3'd0;
            prescaler_r            <= '0;
            seconds_left           <= TURN_VAL;
            {sec_tens, sec_ones}   <= to_bcd(TURN_VAL);
            timer_out              <= 1'b0;
            timer_active           <= 1'b0;
        end else begin
            prev_state_r <= current_state;
            timer_out    <= 1'b0;
            if (!player_turn_s) begin
                state_r              <= IDLE;
                prescaler_r          <= '0;
                seconds_left         <= TURN_VAL;
                {sec_tens, sec_ones} <= to_bcd(TURN_VAL);
                timer_active         <= 1'b0;
            end else if (reload_s) begin
                state_r              <= RUNNING;
                prescaler_r          <= '0;
                seconds_left         <= TURN_VAL;
                {sec_tens, sec_ones} <= to_bcd(TURN_VAL);
                timer_active         <= 1'b1;
            end else begin
                case (state_r)
                    RUNNING: begin
                        if (tick_s) begin
                            prescaler_r <= '0;
                            // Final tick: land on zero and strobe once.
                            if (seconds_left < 5'd2) begin
                                state_r              <= EXPIRED;
                                seconds_left         <= 5'd0;
                                {sec_tens, sec_ones} <= 8'd0;
                                timer_out            <= 1'b1;
                                timer_active         <= 1'b0;
                            end else begin
                                state_r              <= RUNNING;
                                seconds_left         <= seconds_left - 5'd1;
                                {sec_tens, sec_ones} <= to_bcd(seconds_left - 5'd1);
                                timer_active         <= 1'b1;
                            end
                        end else begin
                            state_r      <= RUNNING;
                            prescaler_r  <= prescaler_r + 1'b1;
                            timer_active <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                        state_r              <= EXPIRED;
                        prescaler_r          <= '0;
                        seconds_left         <= 5'd0;
                        {sec_tens, sec_ones} <= 8'd0;
                        timer_active         <= 1'b0;
                    end
                    default: begin
                        state_r      <= IDLE;
                        prescaler_r  <= '0;
                        timer_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_timer.sv
// Scoreboard bench for turn_timer: two instances (3 s and 25 s turns) share random stimulus,
// and a reference model based on elapsed cycles since turn start predicts every cycle.
module tb_turn_timer;

    localparam int F   = 4;
    localparam int T_A = 3;
    localparam int T_B = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cs  = 3'd0;
    logic       mov = 1'b0;

    logic       tout_a, act_a, tout_b, act_b;
    logic [4:0] sec_a, sec_b;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;

    always #5 clk = ~clk;

    turn_timer #(.CLK_FREQ(F), .TURN_SECONDS(T_A)) dut_a (
        .clk(clk), .rst(rst), .current_state(cs), .player_mov(mov),
        .timer_out(tout_a), .seconds_left(sec_a), .sec_tens(tens_a),
        .sec_ones(ones_a), .timer_active(act_a)
    );

    turn_timer #(.CLK_FREQ(F), .TURN_SECONDS(T_B)) dut_b (
        .clk(clk), .rst(rst), .current_state(cs), .player_mov(mov),
        .timer_out(tout_b), .seconds_left(sec_b), .sec_tens(tens_b),
        .sec_ones(ones_b), .timer_active(act_b)
    );

    typedef struct {
        logic [2:0] prev;
        bit         in_turn;
        int         elapsed;
        bit         tout;
    } mdl_t;

    typedef struct {
        int tout;
        int sec;
        int tens;
        int ones;
        int act;
    } exp_t;

    mdl_t m_a, m_b;
    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors = 0;
    int   miscompares = 0;

    // One clock edge of the reference: a turn is "elapsed cycles since its start".
    function automatic mdl_t mdl_step(mdl_t m, bit r, logic [2:0] c, bit mv, int tsec);
        mdl_t n;
        bit   pturn;
        n = m;
        n.tout = 0;
        if (r) begin
            n.prev = 3'd0; n.in_turn = 0; n.elapsed = 0;
        end else begin
            pturn = (c == 3'd1) || (c == 3'd2);
            if (!pturn) begin
                n.in_turn = 0; n.elapsed = 0;
            end else if (mv || (c != m.prev)) begin
                n.in_turn = 1; n.elapsed = 0;
            end else if (m.in_turn && m.elapsed < tsec * F) begin
                n.elapsed = m.elapsed + 1;
                n.tout = (n.elapsed == tsec * F);
            end
            n.prev = c;
        end
        return n;
    endfunction

    function automatic exp_t mdl_out(mdl_t m, int tsec);
        exp_t e;
        if (!m.in_turn) begin
            e.sec = tsec; e.act = 0; e.tout = 0;
        end else begin
            e.sec  = tsec - m.elapsed / F;
            e.act  = (m.elapsed < tsec * F) ? 1 : 0;
            e.tout = m.tout ? 1 : 0;
        end
        e.tens = e.sec / 10;
        e.ones = e.sec % 10;
        return e;
    endfunction

    task automatic check(string name, exp_t e, logic to, logic [4:0] s,
                         logic [3:0] tn, logic [3:0] on, logic ac);
        vectors++;
        if (int'(to) != e.tout || int'(s) != e.sec || int'(tn) != e.tens ||
            int'(on) != e.ones || int'(ac) != e.act) begin
            miscompares++;
            $display("FAIL %s @%0t: got tout=%0d sec=%0d bcd=%0d%0d act=%0d, expected tout=%0d sec=%0d bcd=%0d%0d act=%0d",
                     name, $time, to, s, tn, on, ac, e.tout, e.sec, e.tens, e.ones, e.act);
        end
    endtask

    // Drive one cycle of inputs and queue the predicted post-edge outputs.
    task automatic drive(bit r, logic [2:0] c, bit mv);
        @(negedge clk);
        rst = r; cs = c; mov = mv;
        m_a = mdl_step(m_a, r, c, mv, T_A);
        m_b = mdl_step(m_b, r, c, mv, T_B);
        q_a.push_back(mdl_out(m_a, T_A));
        q_b.push_back(mdl_out(m_b, T_B));
    endtask

    // Monitor: compare the DUT against queued expectations just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("turn3", e, tout_a, sec_a, tens_a, ones_a, act_a);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("turn25", e, tout_b, sec_b, tens_b, ones_b, act_b);
            end
        end
    end

    initial begin
        logic [2:0] c;
        m_a = '{prev: 3'd0, in_turn: 0, elapsed: 0, tout: 0};
        m_b = m_a;

        repeat (2) drive(1'b1, 3'd0, 1'b0);
        // Full countdown and expiry from START -> PLAYER_1.
        repeat (3) drive(1'b0, 3'd0, 1'b0);
        repeat (20) drive(1'b0, 3'd1, 1'b0);
        // Mid-turn move reload, then a move on the exact final tick.
        repeat (6) drive(1'b0, 3'd2, 1'b0);
        drive(1'b0, 3'd2, 1'b1);
        repeat (11) drive(1'b0, 3'd2, 1'b0);
        drive(1'b0, 3'd2, 1'b1);
        repeat (14) drive(1'b0, 3'd2, 1'b0);
        // Turn change then WIN mid-count.
        repeat (5) drive(1'b0, 3'd1, 1'b0);
        repeat (5) drive(1'b0, 3'd3, 1'b0);
        // Reset landing on the pending final tick.
        repeat (12) drive(1'b0, 3'd1, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        repeat (3) drive(1'b0, 3'd0, 1'b0);
        // Long turn so the 25 s instance walks through its BCD range and expires.
        repeat (110) drive(1'b0, 3'd2, 1'b0);

        c = 3'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) c = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 299) == 0), c, ($urandom_range(0, 14) == 0));
        end

        for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", q_a.size() + q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/turn_timer.md
TURN_TIMER -- requirements
Module: turn_timer

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock cycles per one-second tick; legal range >= 2.
REQ-002 Parameter TURN_SECONDS, default 10, seconds allowed per turn; legal range 1..31.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 current_state  input  3  game FSM state: 0=START, 1=PLAYER_1, 2=PLAYER_2, 3=WIN, 4=DRAW, 5..7 treated as START.
REQ-006 player_mov  input  1  single-cycle strobe, current player committed a move.
REQ-007 timer_out  output  1  single-cycle strobe, turn time expired; consumed by the game FSM.
REQ-008 seconds_left  output  5  remaining seconds of current turn, binary.
REQ-009 sec_tens  output  4  BCD tens digit of seconds_left, for 7-segment display.
REQ-010 sec_ones  output  4  BCD ones digit of seconds_left.
REQ-011 timer_active  output  1  high while a turn countdown is running.

Function
REQ-012 Internal FSM states SHALL be IDLE, RUNNING and EXPIRED; all outputs SHALL be registered.
REQ-013 prev_state register SHALL hold current_state delayed one cycle; "turn_change" = current_state != prev_state.
REQ-014 "player_turn" SHALL be true when current_state is 1 or 2.
REQ-015 "reload" SHALL be (player_mov or turn_change) and player_turn.
REQ-016 On reload, from any state: seconds_left <= TURN_SECONDS, prescaler <= 0, state <= RUNNING, timer_out <= 0.
REQ-017 When not player_turn: state <= IDLE, seconds_left <= TURN_SECONDS, prescaler <= 0, timer_out <= 0; this takes priority over reload.
REQ-018 RUNNING without reload: prescaler increments by 1 per cycle; when prescaler = CLK_FREQ-1 it wraps to 0 and seconds_left decrements by 1 (the tick).
REQ-019 Tick with seconds_left = 1: seconds_left <= 0, timer_out <= 1 for exactly that one following cycle, state <= EXPIRED.
REQ-020 EXPIRED: seconds_left holds 0, prescaler holds 0, timer_out <= 0, no further strobes until a reload.
REQ-021 Simultaneous final tick and reload: reload wins; no timer_out pulse; seconds_left <= TURN_SECONDS.
REQ-022 timer_active SHALL be 1 exactly when state is RUNNING.
REQ-023 sec_tens/sec_ones SHALL equal the BCD split of seconds_left in the same cycle (registered alongside it), tens in 0..3, ones in 0..9.
REQ-024 seconds_left SHALL never underflow below 0 or exceed TURN_SECONDS.
REQ-025 Prescaler width SHALL be $clog2(CLK_FREQ) bits; no prescaler overflow for any legal CLK_FREQ.

Reset
REQ-026 With rst high at a rising edge: state = IDLE, prev_state = 0, prescaler = 0, seconds_left = TURN_SECONDS, BCD digits matching, timer_out = 0, timer_active = 0.
REQ-027 rst SHALL take priority over every other input, including reload and a tick in the same cycle.
REQ-028 Reset mid-countdown SHALL abort the turn with no timer_out pulse; the countdown restarts only after a later turn_change into state 1 or 2.

Verification (CLK_FREQ=4, TURN_SECONDS=3 unless stated)
REQ-029 rst, then current_state 0->1 -> timer_active rises next cycle, seconds_left 3,2,1,0 at 4-cycle spacing, single timer_out pulse coinciding with seconds_left first reading 0, then EXPIRED holding 0.
REQ-030 State 1, player_mov pulsed after 6 cycles -> seconds_left reloads to 3, prescaler restarts, no timer_out ever asserted.
REQ-031 player_mov on the exact cycle of the final tick -> seconds_left = 3, timer_out stays 0.
REQ-032 Timeout, then current_state 1->2 -> fresh countdown from 3; current_state ->3 (WIN) mid-count -> IDLE, timer_active 0, seconds_left 3, no pulse.
REQ-033 rst asserted with seconds_left = 1 and a tick pending -> outputs at reset values, no timer_out.
REQ-034 TURN_SECONDS=25: seconds_left 25 -> sec_tens=2, sec_ones=5; after 6 ticks, 19 -> sec_tens=1, sec_ones=9.
